alu_seq_core: RTL and testbench

Parametrised, clocked successor to the switch-driven combinational ALU muxes. It performs the same four operation classes (arithmetic, logical, comparison, accumulator) on WIDTH-bit operands. Results are registered, and a valid/ready handshake gates operand acceptance. Multiply and divide are iterative and multi-cycle. The board top level drives operands from SW and displays result/flags on LEDR and HEX.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_iter_unit.sv | 70 +++++++
 rtl/alu_seq_core.sv | 167 ++++++++++++++++
 tb/tb_alu_seq_core.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: operation classes, per-class selectors,
// FSM states and the iterative-unit mode.
package alu_pkg;

  localparam logic [1:0] CLS_ARITH = 2'd0;
  localparam logic [1:0] CLS_LOGIC = 2'd1;
  localparam logic [1:0] CLS_CMP   = 2'd2;
  localparam logic [1:0] CLS_ACC   = 2'd3;

  localparam logic [1:0] ARITH_ADD = 2'd0;
  localparam logic [1:0] ARITH_SUB = 2'd1;
  localparam logic [1:0] ARITH_MUL = 2'd2;
  localparam logic [1:0] ARITH_DIV = 2'd3;

  localparam logic [1:0] LOGIC_AND = 2'd0;
  localparam logic [1:0] LOGIC_OR  = 2'd1;
  localparam logic [1:0] LOGIC_XOR = 2'd2;
  localparam logic [1:0] LOGIC_NOT = 2'd3;

  localparam logic [1:0] CMP_EQ  = 2'd0;
  localparam logic [1:0] CMP_GT  = 2'd1;
  localparam logic [1:0] CMP_LT  = 2'd2;
  localparam logic [1:0] CMP_MAX = 2'd3;

  localparam logic [1:0] ACC_ADD  = 2'd0;
  localparam logic [1:0] ACC_CLR  = 2'd1;
  localparam logic [1:0] ACC_LOAD = 2'd2;
  localparam logic [1:0] ACC_READ = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_mode_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared shift-register datapath for shift-add multiply and restoring divide,
// one bit per cycle, WIDTH steps per operation.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 start,
  input  iter_mode_t           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] work_reg;
  logic [WIDTH-1:0]   opnd_reg;
  iter_mode_t         mode_reg;
  logic               busy_reg;
  logic [CW-1:0]      count_reg;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] step;

  // work_reg: mul = {partial product high, remaining multiplier}; div = {remainder, quotient}
  always_comb begin
    mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = work_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_reg};
    step      = work_reg;
    if (mode_reg == ITER_MUL) begin
      step = {mul_sum, work_reg[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      step = {div_shift[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0};
    end else begin
      step = {div_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
    end
  end

  // The final step is presented combinationally so the caller registers it on the WIDTH-th cycle.
  assign done   = busy_reg && (count_reg == CW'(WIDTH - 1));
  assign result = step;

  always_ff @(posedge clk) begin
    if (srst) begin
      work_reg  <= '0;
      opnd_reg  <= '0;
      mode_reg  <= ITER_MUL;
      busy_reg  <= 1'b0;
      count_reg <= '0;
    end else if (start) begin
      work_reg  <= (mode == ITER_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      opnd_reg  <= (mode == ITER_DIV) ? b : a;
      mode_reg  <= mode;
      busy_reg  <= 1'b1;
      count_reg <= '0;
    end else if (busy_reg) begin
      work_reg  <= step;
      count_reg <= count_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU with valid/ready operand handshake: single-cycle arithmetic, logic,
// compare and accumulator ops, plus multi-cycle multiply/divide via alu_iter_unit.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 MAX10_CLK1_50,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op_class,
  input  logic [1:0]           op_sel,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_carry,
  output logic                 flag_zero,
  output logic                 flag_dz
);

  localparam int RW = 2 * WIDTH;

  state_t           state_reg;
  logic [RW-1:0]    acc_reg;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             iter_start;
  iter_mode_t       iter_mode;
  logic             iter_done;
  logic [RW-1:0]    iter_result;

  logic [RW-1:0]    res_next;
  logic             carry_next;
  logic             dz_next;
  logic [RW-1:0]    acc_next;
  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [RW:0]      acc_sum;

  assign in_ready   = (state_reg == IDLE);
  assign accept     = in_valid && in_ready;
  assign is_mul     = (op_class == CLS_ARITH) && (op_sel == ARITH_MUL);
  assign is_div     = (op_class == CLS_ARITH) && (op_sel == ARITH_DIV) && (operand_b != '0);
  assign iter_start = accept && (is_mul || is_div);
  assign iter_mode  = is_div ? ITER_DIV : ITER_MUL;

  always_comb begin
    a_ext      = {{WIDTH{1'b0}}, operand_a};
    b_ext      = {{WIDTH{1'b0}}, operand_b};
    add_sum    = {1'b0, operand_a} + {1'b0, operand_b};
    sub_diff   = operand_a - operand_b;
    acc_sum    = {1'b0, acc_reg} + {1'b0, a_ext};
    res_next   = '0;
    carry_next = 1'b0;
    dz_next    = 1'b0;
    acc_next   = acc_reg;
    case (op_class)
      CLS_ARITH: begin
        case (op_sel)
          ARITH_ADD: begin
            res_next   = RW'(add_sum);
            carry_next = add_sum[WIDTH];
          end
          ARITH_SUB: begin
            res_next   = {{WIDTH{1'b0}}, sub_diff};
            carry_next = (operand_a < operand_b);
          end
          ARITH_DIV: begin
            // Only reached as a single-cycle op when the divisor is zero.
            res_next = {operand_a, {WIDTH{1'b1}}};
            dz_next  = 1'b1;
          end
          default: ;
        endcase
      end
      CLS_LOGIC: begin
        case (op_sel)
          LOGIC_AND: res_next = a_ext & b_ext;
          LOGIC_OR:  res_next = a_ext | b_ext;
          LOGIC_XOR: res_next = a_ext ^ b_ext;
          default:   res_next = {{WIDTH{1'b0}}, ~operand_a};
        endcase
      end
      CLS_CMP: begin
        case (op_sel)
          CMP_EQ:  res_next = RW'(operand_a == operand_b);
          CMP_GT:  res_next = RW'(operand_a > operand_b);
          CMP_LT:  res_next = RW'(operand_a < operand_b);
          default: res_next = (operand_a > operand_b) ? a_ext : b_ext;
        endcase
      end
      default: begin
        case (op_sel)
          ACC_ADD: begin
            acc_next   = acc_sum[RW-1:0];
            carry_next = acc_sum[RW];
          end
          ACC_CLR:  acc_next = '0;
          ACC_LOAD: acc_next = a_ext;
          default:  acc_next = acc_reg;
        endcase
        res_next = acc_next;
      end
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (MAX10_CLK1_50),
    .srst   (reset),
    .start  (iter_start),
    .mode   (iter_mode),
    .a      (operand_a),
    .b      (operand_b),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      flag_dz    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_reg <= MUL;
            end else if (is_div) begin
              state_reg <= DIV;
            end else begin
              out_valid  <= 1'b1;
              result     <= res_next;
              flag_carry <= carry_next;
              flag_zero  <= (res_next == '0);
              flag_dz    <= dz_next;
              acc_reg    <= acc_next;
            end
          end
        end
        MUL, DIV: begin
          if (iter_done) begin
            state_reg  <= IDLE;
            out_valid  <= 1'b1;
            result     <= iter_result;
            flag_carry <= 1'b0;
            flag_zero  <= (iter_result == '0);
            flag_dz    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed plan steps followed by random ops,
// all compared against an arithmetic reference model of the ALU.
module tb_alu_seq_core;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op_class;
  logic [1:0]    op_sel;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          out_valid;
  logic [RW-1:0] result;
  logic          flag_carry;
  logic          flag_zero;
  logic          flag_dz;

  int errors = 0;
  int checks = 0;
  int acc_m  = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_class      (op_class),
    .op_sel        (op_sel),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .out_valid     (out_valid),
    .result        (result),
    .flag_carry    (flag_carry),
    .flag_zero     (flag_zero),
    .flag_dz       (flag_dz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op, let it be accepted at the next edge, and check the result cycle.
  task automatic run_op(input string tag, input int cls, input int sel, input int a, input int b);
    int exp_res;
    int exp_c;
    int exp_dz;
    bit multi;
    exp_res = 0;
    exp_c   = 0;
    exp_dz  = 0;
    multi   = 1'b0;
    case (cls)
      0: case (sel)
           0: begin exp_res = a + b; exp_c = (a + b > 15) ? 1 : 0; end
           1: begin exp_res = (a - b) & 15; exp_c = (a < b) ? 1 : 0; end
           2: begin exp_res = a * b; multi = 1'b1; end
           default: if (b == 0) begin
                      exp_res = a * 16 + 15; exp_dz = 1;
                    end else begin
                      exp_res = (a % b) * 16 + a / b; multi = 1'b1;
                    end
         endcase
      1: case (sel)
           0: exp_res = a & b;
           1: exp_res = a | b;
           2: exp_res = a ^ b;
           default: exp_res = (~a) & 15;
         endcase
      2: case (sel)
           0: exp_res = (a == b) ? 1 : 0;
           1: exp_res = (a > b) ? 1 : 0;
           2: exp_res = (a < b) ? 1 : 0;
           default: exp_res = (a > b) ? a : b;
         endcase
      default: begin
        case (sel)
          0: begin acc_m = acc_m + a; exp_c = (acc_m > 255) ? 1 : 0; acc_m = acc_m & 255; end
          1: acc_m = 0;
          2: acc_m = a;
          default: ;
        endcase
        exp_res = acc_m;
      end
    endcase

    in_valid  = 1'b1;
    op_class  = 2'(cls);
    op_sel    = 2'(sel);
    operand_a = W'(a);
    operand_b = W'(b);
    tick;
    in_valid = 1'b0;
    if (multi) begin
      for (int i = 0; i < W; i++) begin
        check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
        // An acc add offered while busy must be dropped without effect.
        in_valid = (i == 1);
        op_class = 2'd3;
        op_sel   = 2'd0;
        operand_a = 4'd1;
        tick;
      end
      in_valid = 1'b0;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_carry"}, 32'(flag_carry), 32'(exp_c));
    check({tag, "_zero"}, 32'(flag_zero), (exp_res == 0) ? 32'd1 : 32'd0);
    check({tag, "_dz"}, 32'(flag_dz), 32'(exp_dz));
    $display("op %s cls=%0d sel=%0d a=%0d b=%0d result=%0h expected=%0h", tag, cls, sel, a, b, result, exp_res);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op_class  = '0;
    op_sel    = '0;
    operand_a = '0;
    operand_b = '0;
    tick;
    tick;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, flag_carry, flag_zero, flag_dz}, 32'd0);
    reset = 1'b0;
    tick;

    run_op("add_9_8", 0, 0, 9, 8);
    run_op("sub_3_5", 0, 1, 3, 5);
    run_op("mul_15_13", 0, 2, 15, 13);
    run_op("div_13_4", 0, 3, 13, 4);
    run_op("div_7_0", 0, 3, 7, 0);
    run_op("mul_0_9", 0, 2, 0, 9);
    run_op("div_0_3", 0, 3, 0, 3);
    run_op("cmp_max", 2, 3, 5, 12);
    run_op("cmp_lt", 2, 2, 5, 12);
    run_op("cmp_eq", 2, 0, 5, 12);
    run_op("logic_not", 1, 3, 15, 3);
    run_op("acc_load9", 3, 2, 9, 0);
    run_op("acc_add9", 3, 0, 9, 0);
    run_op("acc_clr", 3, 1, 0, 0);
    run_op("acc_load15", 3, 2, 15, 0);
    for (int i = 0; i < 17; i++) run_op("acc_add15", 3, 0, 15, 0);

    // Reset in the middle of a multiply must abort it silently.
    in_valid  = 1'b1;
    op_class  = 2'd0;
    op_sel    = 2'd2;
    operand_a = 4'd15;
    operand_b = 4'd13;
    tick;
    in_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    acc_m = 0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {29'd0, flag_carry, flag_zero, flag_dz}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      tick;
    end
    run_op("acc_read_after_rst", 3, 3, 6, 0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
